// File: rtl/dram_controller_if.sv
// dram_controller_if: read/write requester handshake between the AXI DRAM slave and the controller
interface dram_controller_if;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_done;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_wen_n;
  logic        wr_done;
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_wen_n,
    input  rd_data, rd_done, wr_done
  );
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_wen_n,
    output rd_data, rd_done, wr_done
  );
endinterface

// File: rtl/dram_controller.sv
// dram_controller: open-page DRAM command sequencer arbitrating one read and one write requester
module dram_controller #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int T_RP     = 5,
  parameter int T_RCD    = 5,
  parameter int T_WR     = 5
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  dram_controller_if.slave    bus,
  output logic                CSn,
  output logic                RASn,
  output logic                CASn,
  output logic [3:0]          WEn,
  output logic [ROW_BITS-1:0] A,
  output logic [31:0]         D,
  input  logic [31:0]         Q,
  input  logic                VALID
);
  typedef enum logic [2:0] {IDLE, PRE, ACT, WR, RD, RD_WAIT, DONE} state_t;
  state_t state, next_state;
  logic [7:0] cnt;
  logic [31:0] addr_q, data_q, sel_addr, sel_data;
  logic [3:0] wen_q, sel_wen, n_wen;
  logic op_rd, last_rd, row_open, serve_rd, is_rd, go;
  logic cmd_pre, cmd_act, cmd_rd, cmd_wr, n_rasn, n_casn;
  logic [ROW_BITS-1:0] open_row, row, col, n_a;
  logic [31:0] n_d;
  logic unused_bits;
  // In IDLE the request is taken straight from the requester so the first command can issue next cycle
  assign serve_rd    = bus.rd_req && (!bus.wr_req || !last_rd);
  assign sel_addr    = state == IDLE ? (serve_rd ? bus.rd_addr : bus.wr_addr) : addr_q;
  assign sel_data    = state == IDLE ? bus.wr_data : data_q;
  assign sel_wen     = state == IDLE ? bus.wr_wen_n : wen_q;
  assign is_rd       = state == IDLE ? serve_rd : op_rd;
  assign row         = sel_addr[ROW_BITS+11:12];
  assign col         = ROW_BITS'(sel_addr[COL_BITS+1:2]);
  assign unused_bits = ^sel_addr;
  assign go          = next_state != state;
  assign cmd_pre     = go && next_state == PRE;
  assign cmd_act     = go && next_state == ACT;
  assign cmd_rd      = go && next_state == RD;
  assign cmd_wr      = go && next_state == WR;
  // State, phase timer, latched request and open-row bookkeeping
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      wen_q    <= 4'hF;
      op_rd    <= 1'b0;
      last_rd  <= 1'b0;
      row_open <= 1'b0;
      open_row <= '0;
    end else begin
      state <= next_state;
      cnt   <= cmd_pre ? 8'(T_RP - 1) : cmd_act ? 8'(T_RCD - 1) : cmd_wr ? 8'(T_WR - 1) :
               cnt == 8'd0 ? cnt : cnt - 8'd1;
      if (state == IDLE) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
        wen_q  <= sel_wen;
        op_rd  <= serve_rd;
      end
      if (cmd_act) begin
        row_open <= 1'b1;
        open_row <= row;
      end
      if (state == DONE) last_rd <= op_rd;
    end
  end
  // Next-state selection: arbitration and row decision in IDLE, phase timing elsewhere
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.rd_req || bus.wr_req)
                 next_state = (row_open && open_row == row) ? (serve_rd ? RD : WR) : row_open ? PRE : ACT;
      PRE:     if (cnt == 8'd0) next_state = ACT;
      ACT:     if (cnt == 8'd0) next_state = op_rd ? RD : WR;
      WR:      if (cnt == 8'd0) next_state = DONE;
      RD:      next_state = RD_WAIT;
      RD_WAIT: if (VALID) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  // Command pin values for the cycle about to start; a command only on the first cycle of its phase
  always_comb begin
    n_rasn = !(cmd_pre || cmd_act);
    n_casn = !(cmd_rd || cmd_wr);
    n_wen  = cmd_pre ? 4'h0 : cmd_wr ? sel_wen : 4'hF;
    n_a    = cmd_pre ? open_row : cmd_act ? row : (cmd_rd || cmd_wr) ? col : A;
    n_d    = cmd_wr ? sel_data : D;
  end
  // Registered DRAM pins and completion pulses
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      CSn         <= 1'b1;
      RASn        <= 1'b1;
      CASn        <= 1'b1;
      WEn         <= 4'hF;
      A           <= '0;
      D           <= 32'd0;
      bus.rd_data <= 32'd0;
      bus.rd_done <= 1'b0;
      bus.wr_done <= 1'b0;
    end else begin
      CSn         <= 1'b0;
      RASn        <= n_rasn;
      CASn        <= n_casn;
      WEn         <= n_wen;
      A           <= n_a;
      D           <= n_d;
      bus.rd_data <= (state == RD_WAIT && VALID) ? Q : bus.rd_data;
      bus.rd_done <= go && next_state == DONE && is_rd;
      bus.wr_done <= go && next_state == DONE && !is_rd;
    end
  end
endmodule

// File: tb/tb_dram_controller.sv
// tb_dram_controller: directed-vector bench for the DRAM command sequencer
module tb_dram_controller;
  logic ACLK, ARESETn, CSn, RASn, CASn, VALID;
  logic [3:0] WEn;
  logic [10:0] A;
  logic [31:0] D, Q;
  dram_controller_if bus();
  dram_controller dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus), .CSn(CSn), .RASn(RASn), .CASn(CASn),
    .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID)
  );
  int n_chk = 0, n_pass = 0;
  int ncmd, rd_cnt, wr_cnt, rd_cyc, wr_cyc;
  int k[8], cy[8];
  logic [10:0] la[8];
  logic [3:0] lw[8];
  logic [31:0] ld[8];
  logic [31:0] got_rd;
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // 1=PRE 2=ACT 3=RD 4=WR 0=none
  function automatic int kind();
    return (!RASn && CASn && WEn == 4'h0) ? 1 : (!RASn && CASn && WEn == 4'hF) ? 2 :
           (RASn && !CASn && WEn == 4'hF) ? 3 : (RASn && !CASn) ? 4 : 0;
  endfunction
  task automatic check_reset(input string tag);
    check({tag, "_csn"}, CSn, 1'b1);
    check({tag, "_rasn"}, RASn, 1'b1);
    check({tag, "_casn"}, CASn, 1'b1);
    check({tag, "_wen"}, WEn, 4'hF);
    check({tag, "_a"}, A, 11'd0);
    check({tag, "_done"}, {bus.rd_done, bus.wr_done}, 2'b00);
    check({tag, "_rdata"}, bus.rd_data, 32'd0);
  endtask
  // Cycle 0 is the IDLE cycle in which requests are first seen; outputs sampled at negedge of cycle c
  task automatic run(input bit rq, input logic [31:0] ra, input bit wq, input logic [31:0] wa,
                     input logic [31:0] wd, input logic [3:0] wn, input int vc, input logic [31:0] q,
                     input int rst_at, input int ncyc);
    ncmd = 0; rd_cnt = 0; wr_cnt = 0; rd_cyc = -1; wr_cyc = -1; got_rd = 32'hx;
    @(negedge ACLK);
    bus.rd_req = rq; bus.rd_addr = ra;
    bus.wr_req = wq; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_wen_n = wn;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge ACLK);
      if (!CSn && (!RASn || !CASn) && ncmd < 8) begin
        k[ncmd] = kind(); cy[ncmd] = c; la[ncmd] = A; lw[ncmd] = WEn; ld[ncmd] = D;
        ncmd++;
      end
      if (bus.rd_done) begin rd_cnt++; rd_cyc = c; got_rd = bus.rd_data; bus.rd_req = 1'b0; end
      if (bus.wr_done) begin wr_cnt++; wr_cyc = c; bus.wr_req = 1'b0; end
      VALID = rq && c == vc;
      Q = VALID ? q : 32'h0BAD_0BAD;
      if (c == rst_at) begin
        ARESETn = 1'b0;
        #1 check_reset("midrst");
        #1 ARESETn = 1'b1;
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      end
    end
  endtask
  initial begin
    ARESETn = 1'b1; VALID = 1'b0; Q = 32'd0;
    bus.rd_req = 1'b0; bus.rd_addr = 32'd0; bus.wr_req = 1'b0;
    bus.wr_addr = 32'd0; bus.wr_data = 32'd0; bus.wr_wen_n = 4'hF;
    #2 ARESETn = 1'b0;
    #1 check_reset("rst");
    repeat (2) @(negedge ACLK);
    check_reset("rst_hold");
    ARESETn = 1'b1;
    // write to closed row: ACT then WR
    run(0, 0, 1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h0, 0, 0, 0, 14);
    check("w1_ncmd", ncmd, 2);
    check("w1_act", {k[0], cy[0], 21'(la[0])}, {32'd2, 32'd1, 21'd1});
    check("w1_wr", {k[1], cy[1], 21'(la[1]), 4'(lw[1])}, {32'd4, 32'd6, 21'd1, 4'h0});
    check("w1_d", ld[1], 32'hDEAD_BEEF);
    check("w1_done", {wr_cnt, wr_cyc, rd_cnt}, {32'd1, 32'd11, 32'd0});
    // read hit on the open row
    run(1, 32'h0000_1008, 0, 0, 0, 4'hF, 4, 32'h1234_5678, 0, 8);
    check("r1_ncmd", ncmd, 1);
    check("r1_rd", {k[0], cy[0], 21'(la[0])}, {32'd3, 32'd1, 21'd2});
    check("r1_done", {rd_cnt, rd_cyc, wr_cnt}, {32'd1, 32'd5, 32'd0});
    check("r1_data", got_rd, 32'h1234_5678);
    // write with row conflict: PRE, ACT, WR
    run(0, 0, 1, 32'h0000_2000, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 19);
    check("w2_ncmd", ncmd, 3);
    check("w2_pre", {k[0], cy[0], 21'(la[0]), 4'(lw[0])}, {32'd1, 32'd1, 21'd1, 4'h0});
    check("w2_act", {k[1], cy[1], 21'(la[1])}, {32'd2, 32'd6, 21'd2});
    check("w2_wr", {k[2], cy[2], 21'(la[2]), 4'(lw[2])}, {32'd4, 32'd11, 21'd0, 4'hC});
    check("w2_d", ld[2], 32'hCAFE_F00D);
    check("w2_done", {wr_cnt, wr_cyc}, {32'd1, 32'd16});
    // simultaneous requests after a write: read first, write follows
    run(1, 32'h0000_2010, 1, 32'h0000_2014, 32'h55AA_55AA, 4'h3, 3, 32'hA5A5_0001, 0, 14);
    check("rr_ncmd", ncmd, 2);
    check("rr_rd", {k[0], cy[0], 21'(la[0])}, {32'd3, 32'd1, 21'd4});
    check("rr_wr", {k[1], cy[1], 21'(la[1]), 4'(lw[1])}, {32'd4, 32'd6, 21'd5, 4'h3});
    check("rr_rdone", {rd_cnt, rd_cyc}, {32'd1, 32'd4});
    check("rr_wdone", {wr_cnt, wr_cyc}, {32'd1, 32'd11});
    check("rr_data", got_rd, 32'hA5A5_0001);
    // reset during ACT of a conflict miss: no completion
    run(0, 0, 1, 32'h0000_3000, 32'h1111_2222, 4'h0, 0, 0, 7, 10);
    check("ab_ncmd", ncmd, 2);
    check("ab_seq", {k[0], cy[0], k[1], cy[1]}, {32'd1, 32'd1, 32'd2, 32'd6});
    check("ab_done", {rd_cnt, wr_cnt}, {32'd0, 32'd0});
    // retry: row state forgotten, so ACT with no PRE
    run(0, 0, 1, 32'h0000_3000, 32'h0F0F_0F0F, 4'h5, 0, 0, 0, 14);
    check("rt_ncmd", ncmd, 2);
    check("rt_act", {k[0], cy[0], 21'(la[0])}, {32'd2, 32'd1, 21'd3});
    check("rt_wr", {k[1], cy[1], 21'(la[1]), 4'(lw[1])}, {32'd4, 32'd6, 21'd0, 4'h5});
    check("rt_done", {wr_cnt, wr_cyc}, {32'd1, 32'd11});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
